potential_sweep_ctrl: RTL

Sequencer on the far side of the neuron group selector. It drives the 6-bit output/input group selects and the input-enable, and sweeps all 64 sixteen-neuron groups. Each group carries 128 bits (16 × 8-bit potentials). The block saves every group's potential into an internal 64 × 128 bank, restores the bank back into the neurons, or clears both. It sits between the neuron array/selector and the time-step controller, and gives the host a read port into the bank.

---
 rtl/potential_sweep_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/potential_sweep_ctrl.sv
// potential_sweep_ctrl
//   Sweeps all neuron groups through the group selector to save their
//   potentials into an internal bank, restore the bank back into the
//   neurons, or clear both. A registered host read port exposes the bank.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, op                sweep request (sampled in IDLE only) and opcode
//                            0 = SAVE, 1 = RESTORE, 2 = CLEAR, 3 = ignored
//   busy, done               sweep running / one-cycle completion pulse
//   cntrl_potential_out_sel  group read from the neurons during SAVE
//   potential_out_16n        potentials of the selected group (combinational)
//   cntrl_potential_in_sel   group written to the neurons (RESTORE/CLEAR)
//   cntrl_potential_in_ien   neuron write enable
//   potential_in_16n         data written to the selected group
//   host_rd_addr/_data       bank read port, one cycle latency
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for start with a valid op
// SAVE    | bank[grp] <= neuron group grp, one group per cycle
// RESTORE | neuron group grp <= bank[grp]
// CLEAR   | neuron group grp <= 0 and bank[grp] <= 0
// DONE    | one-cycle done pulse, then back to IDLE
module potential_sweep_ctrl #(
    parameter int GROUPS  = 64,
    parameter int SEL_W   = 6,
    parameter int GROUP_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [SEL_W-1:0]   cntrl_potential_out_sel,
    input  logic [GROUP_W-1:0] potential_out_16n,
    output logic [SEL_W-1:0]   cntrl_potential_in_sel,
    output logic               cntrl_potential_in_ien,
    output logic [GROUP_W-1:0] potential_in_16n,
    input  logic [SEL_W-1:0]   host_rd_addr,
    output logic [GROUP_W-1:0] host_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   grp, grp_nxt;
    logic [GROUP_W-1:0] bank [GROUPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            grp   <= '0;
        end else begin
            state <= state_nxt;
            grp   <= grp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grp_nxt   = grp;
        case (state)
            S_IDLE: begin
                grp_nxt = '0;
                if (start) begin
                    case (op)
                        2'd0:    state_nxt = S_SAVE;
                        2'd1:    state_nxt = S_RESTORE;
                        2'd2:    state_nxt = S_CLEAR;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_SAVE, S_RESTORE, S_CLEAR: begin
                // The counter wraps to 0 exactly as the sweep ends.
                grp_nxt = grp + 1'b1;
                if (grp == SEL_W'(GROUPS - 1))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                grp_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                grp_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_SAVE) || (state == S_RESTORE) || (state == S_CLEAR);
    assign done = (state == S_DONE);
    assign cntrl_potential_out_sel = (state == S_SAVE) ? grp : '0;

    // Write-side outputs are registered from the next state/group so that
    // select, enable and data all change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntrl_potential_in_sel <= '0;
            cntrl_potential_in_ien <= 1'b0;
            potential_in_16n       <= '0;
        end else begin
            cntrl_potential_in_sel <= '0;
            cntrl_potential_in_ien <= 1'b0;
            potential_in_16n       <= '0;
            if (state_nxt == S_RESTORE) begin
                cntrl_potential_in_sel <= grp_nxt;
                cntrl_potential_in_ien <= 1'b1;
                potential_in_16n       <= bank[grp_nxt];
            end else if (state_nxt == S_CLEAR) begin
                cntrl_potential_in_sel <= grp_nxt;
                cntrl_potential_in_ien <= 1'b1;
            end
        end
    end

    // Host read samples the pre-write contents, so a same-cycle read of the
    // entry being written returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GROUPS; i++)
                bank[i] <= '0;
            host_rd_data <= '0;
        end else begin
            host_rd_data <= bank[host_rd_addr];
            if (state == S_SAVE)
                bank[grp] <= potential_out_16n;
            else if (state == S_CLEAR)
                bank[grp] <= '0;
        end
    end

endmodule
